// File: rtl/uart_phy.sv
// uart_phy: full-duplex 8N1 UART transceiver, 16x oversampled RX with mid-bit sampling,
// start-glitch rejection and framing-error detection; RX and TX run on independent prescalers.
module uart_phy #(
    parameter int CLOCK_DIVIDE = 27
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic       tx_o,
    input  logic       transmit_i,
    input  logic [7:0] tx_byte_i,
    output logic       received_o,
    output logic [7:0] rx_byte_o,
    output logic       is_receiving_o,
    output logic       is_transmitting_o,
    output logic       recv_error_o
);
    localparam int PW = $clog2(CLOCK_DIVIDE);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLOCK_DIVIDE - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;

    logic          rx_meta_q, rxs_q;
    tx_state_e     tx_state_q, tx_state_d;
    logic [PW-1:0] tx_presc_q, tx_presc_d;
    logic [3:0]    tx_tick_q, tx_tick_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_data_q, tx_data_d;
    rx_state_e     rx_state_q, rx_state_d;
    logic [PW-1:0] rx_presc_q, rx_presc_d;
    logic [3:0]    rx_tick_q, rx_tick_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          received_q, received_d;
    logic          recv_error_q, recv_error_d;
    logic          tx_tick, tx_bit_end, rx_tick;

    assign tx_tick    = tx_presc_q == PRESC_MAX;
    assign tx_bit_end = tx_tick && tx_tick_q == 4'd15;
    assign rx_tick    = rx_presc_q == PRESC_MAX;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_presc_d = tx_tick ? '0 : tx_presc_q + 1'b1;
        tx_tick_d  = tx_tick ? tx_tick_q + 4'd1 : tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_data_d  = tx_data_q;
        case (tx_state_q)
            TX_IDLE: if (transmit_i) begin
                tx_state_d = TX_START;
                tx_data_d  = tx_byte_i;
                tx_presc_d = '0;
                tx_tick_d  = '0;
                tx_bit_d   = '0;
            end
            TX_START: if (tx_bit_end) tx_state_d = TX_DATA;
            TX_DATA: if (tx_bit_end) begin
                tx_bit_d   = tx_bit_q + 3'd1;
                tx_state_d = tx_bit_q == 3'd7 ? TX_STOP : TX_DATA;
            end
            TX_STOP: if (tx_bit_end) tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // The start sample lands on tick 7 (mid-bit); later samples are 16 ticks apart.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_presc_d   = rx_tick ? '0 : rx_presc_q + 1'b1;
        rx_tick_d    = rx_tick ? rx_tick_q + 4'd1 : rx_tick_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_byte_d    = rx_byte_q;
        received_d   = 1'b0;
        recv_error_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (!rxs_q) begin
                rx_state_d = RX_START;
                rx_presc_d = '0;
                rx_tick_d  = '0;
                rx_bit_d   = '0;
            end
            RX_START: if (rx_tick && rx_tick_q == 4'd7) begin
                rx_tick_d  = '0;
                rx_state_d = rxs_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_tick && rx_tick_q == 4'd15) begin
                rx_shift_d = {rxs_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                rx_state_d = rx_bit_q == 3'd7 ? RX_STOP : RX_DATA;
            end
            RX_STOP: if (rx_tick && rx_tick_q == 4'd15) begin
                rx_state_d   = rxs_q ? RX_IDLE : RX_WAIT_HIGH;
                rx_byte_d    = rxs_q ? rx_shift_q : rx_byte_q;
                received_d   = rxs_q;
                recv_error_d = !rxs_q;
            end
            RX_WAIT_HIGH: if (rxs_q) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q    <= 1'b1;
            rxs_q        <= 1'b1;
            tx_state_q   <= TX_IDLE;
            tx_presc_q   <= '0;
            tx_tick_q    <= '0;
            tx_bit_q     <= '0;
            tx_data_q    <= '0;
            rx_state_q   <= RX_IDLE;
            rx_presc_q   <= '0;
            rx_tick_q    <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_byte_q    <= '0;
            received_q   <= 1'b0;
            recv_error_q <= 1'b0;
        end else begin
            rx_meta_q    <= rx_i;
            rxs_q        <= rx_meta_q;
            tx_state_q   <= tx_state_d;
            tx_presc_q   <= tx_presc_d;
            tx_tick_q    <= tx_tick_d;
            tx_bit_q     <= tx_bit_d;
            tx_data_q    <= tx_data_d;
            rx_state_q   <= rx_state_d;
            rx_presc_q   <= rx_presc_d;
            rx_tick_q    <= rx_tick_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_byte_q    <= rx_byte_d;
            received_q   <= received_d;
            recv_error_q <= recv_error_d;
        end
    end

    assign tx_o              = tx_state_q == TX_START ? 1'b0 :
                               tx_state_q == TX_DATA  ? tx_data_q[tx_bit_q] : 1'b1;
    assign is_transmitting_o = tx_state_q != TX_IDLE;
    assign is_receiving_o    = rx_state_q == RX_START || rx_state_q == RX_DATA || rx_state_q == RX_STOP;
    assign received_o        = received_q;
    assign recv_error_o      = recv_error_q;
    assign rx_byte_o         = rx_byte_q;
endmodule

// File: tb/tb_uart_phy.sv
// tb_uart_phy: directed tests of uart_phy with CLOCK_DIVIDE=4 (64 clocks per bit).
module tb_uart_phy;
    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       rx_drv = 1'b1;
    logic       loop = 1'b0;
    logic       rx_line;
    logic       tx_o;
    logic       transmit_i = 1'b0;
    logic [7:0] tx_byte_i = 8'h00;
    logic       received_o;
    logic [7:0] rx_byte_o;
    logic       is_receiving_o;
    logic       is_transmitting_o;
    logic       recv_error_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rcv_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int dbl_cnt = 0;
    int last_rcv_cyc = 0;
    logic rcv_busy = 1'b0;
    logic prev_rcv = 1'b0;
    logic prev_err = 1'b0;
    logic [7:0] rcv_q[$];

    assign rx_line = loop ? tx_o : rx_drv;

    uart_phy #(.CLOCK_DIVIDE(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .rx_i(rx_line), .tx_o(tx_o),
        .transmit_i(transmit_i), .tx_byte_i(tx_byte_i), .received_o(received_o),
        .rx_byte_o(rx_byte_o), .is_receiving_o(is_receiving_o),
        .is_transmitting_o(is_transmitting_o), .recv_error_o(recv_error_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (received_o) begin
            rcv_cnt++;
            rcv_q.push_back(rx_byte_o);
            last_rcv_cyc = cyc;
            rcv_busy = is_receiving_o;
        end
        if (recv_error_o) err_cnt++;
        if (received_o && recv_error_o) both_cnt++;
        if ((received_o && prev_rcv) || (recv_error_o && prev_err)) dbl_cnt++;
        prev_rcv = received_o;
        prev_err = recv_error_o;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx_drv = f[k];
            repeat (64) step();
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 20; i++) begin
            rx_drv = i[0];
            step();
        end
        checks++;
        if ({tx_o, received_o, rx_byte_o, is_receiving_o, is_transmitting_o, recv_error_o} !== 13'h1000) begin
            errors++;
            $display("FAIL reset_hold outputs got tx=%b rcv=%b byte=%h rxb=%b txb=%b err=%b exp tx=1 others 0",
                     tx_o, received_o, rx_byte_o, is_receiving_o, is_transmitting_o, recv_error_o);
        end
        rx_drv = 1'b1;
        rst_ni = 1'b1;
        step();
        checks++;
        if ({tx_o, received_o, rx_byte_o, is_receiving_o, is_transmitting_o, recv_error_o} !== 13'h1000) begin
            errors++;
            $display("FAIL reset_release outputs got tx=%b rcv=%b byte=%h rxb=%b txb=%b err=%b exp tx=1 others 0",
                     tx_o, received_o, rx_byte_o, is_receiving_o, is_transmitting_o, recv_error_o);
        end
        repeat (1000) step();
        checks++;
        if (rcv_cnt !== 0 || err_cnt !== 0) begin
            errors++;
            $display("FAIL reset_quiet got rcv=%0d err=%0d exp 0 0", rcv_cnt, err_cnt);
        end
    endtask

    task automatic test_tx();
        logic [9:0] frame;
        int bad[10];
        int busy;
        frame = {1'b1, 8'h4C, 1'b0};
        busy = 0;
        for (int k = 0; k < 10; k++) bad[k] = 0;
        transmit_i = 1'b1;
        tx_byte_i  = 8'h4C;
        step();
        for (int i = 0; i < 640; i++) begin
            if (tx_o !== frame[i / 64]) bad[i / 64]++;
            if (is_transmitting_o) busy++;
            transmit_i = (i == 200);
            tx_byte_i  = (i == 200) ? 8'hFF : 8'h4C;
            step();
        end
        transmit_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (bad[k] !== 0) begin
                errors++;
                $display("FAIL tx_cell%0d wrong cycles got %0d exp 0 (level %b)", k, bad[k], frame[k]);
            end
        end
        checks++;
        if (busy !== 640) begin
            errors++;
            $display("FAIL tx_busy_len got %0d exp 640", busy);
        end
        checks++;
        if (is_transmitting_o !== 1'b0 || tx_o !== 1'b1) begin
            errors++;
            $display("FAIL tx_end got txb=%b tx=%b exp 0 1", is_transmitting_o, tx_o);
        end
        repeat (700) step();
        checks++;
        if (is_transmitting_o !== 1'b0 || tx_o !== 1'b1) begin
            errors++;
            $display("FAIL tx_no_queue got txb=%b tx=%b exp 0 1", is_transmitting_o, tx_o);
        end
    endtask

    task automatic test_rx();
        int r0, t0, dt;
        r0 = rcv_cnt;
        t0 = cyc;
        send_rx(8'h53, 1'b1);
        repeat (20) step();
        dt = last_rcv_cyc - t0;
        checks++;
        if (rcv_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL rx_count got %0d exp 1", rcv_cnt - r0);
        end
        checks++;
        if (rx_byte_o !== 8'h53) begin
            errors++;
            $display("FAIL rx_byte got %h exp 53", rx_byte_o);
        end
        checks++;
        if (rcv_busy !== 1'b0 || is_receiving_o !== 1'b0) begin
            errors++;
            $display("FAIL rx_busy got at_pulse=%b now=%b exp 0 0", rcv_busy, is_receiving_o);
        end
        checks++;
        if (dt < 608 || dt > 614) begin
            errors++;
            $display("FAIL rx_latency got %0d exp 608..614", dt);
        end
    endtask

    task automatic test_glitch();
        int r0, e0, w;
        r0 = rcv_cnt;
        e0 = err_cnt;
        rx_drv = 1'b0;
        repeat (20) step();
        checks++;
        if (is_receiving_o !== 1'b1) begin
            errors++;
            $display("FAIL glitch_start got %b exp 1", is_receiving_o);
        end
        rx_drv = 1'b1;
        w = 0;
        while (is_receiving_o && w < 40) begin
            step();
            w++;
        end
        checks++;
        if (is_receiving_o !== 1'b0) begin
            errors++;
            $display("FAIL glitch_abort is_receiving got %b exp 0 after 40 cycles", is_receiving_o);
        end
        repeat (100) step();
        checks++;
        if (rcv_cnt !== r0 || err_cnt !== e0) begin
            errors++;
            $display("FAIL glitch_pulses got rcv=%0d err=%0d exp 0 0", rcv_cnt - r0, err_cnt - e0);
        end
    endtask

    task automatic test_framing();
        int r0, e0;
        r0 = rcv_cnt;
        e0 = err_cnt;
        send_rx(8'hA5, 1'b0);
        repeat (200) step();
        checks++;
        if (err_cnt - e0 !== 1 || rcv_cnt !== r0) begin
            errors++;
            $display("FAIL frame_err got err=%0d rcv=%0d exp 1 0", err_cnt - e0, rcv_cnt - r0);
        end
        checks++;
        if (rx_byte_o !== 8'h53) begin
            errors++;
            $display("FAIL frame_keep_byte got %h exp 53", rx_byte_o);
        end
        checks++;
        if (is_receiving_o !== 1'b0) begin
            errors++;
            $display("FAIL frame_wait_busy got %b exp 0", is_receiving_o);
        end
        rx_drv = 1'b1;
        repeat (20) step();
        send_rx(8'h30, 1'b1);
        repeat (20) step();
        checks++;
        if (rcv_cnt - r0 !== 1 || err_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL frame_recover counts got rcv=%0d err=%0d exp 1 1", rcv_cnt - r0, err_cnt - e0);
        end
        checks++;
        if (rx_byte_o !== 8'h30) begin
            errors++;
            $display("FAIL frame_recover_byte got %h exp 30", rx_byte_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq[3];
        int w, r0, e0;
        seq = '{8'h00, 8'hFF, 8'h5A};
        loop = 1'b1;
        repeat (10) step();
        rcv_q.delete();
        e0 = err_cnt;
        for (int k = 0; k < 3; k++) begin
            w = 0;
            while (is_transmitting_o && w < 1000) begin
                step();
                w++;
            end
            checks++;
            if (is_transmitting_o !== 1'b0) begin
                errors++;
                $display("FAIL b2b_wait%0d is_transmitting got %b exp 0", k, is_transmitting_o);
            end
            transmit_i = 1'b1;
            tx_byte_i  = seq[k];
            step();
            transmit_i = 1'b0;
        end
        repeat (700) step();
        checks++;
        if (rcv_q.size() !== 3) begin
            errors++;
            $display("FAIL b2b_count got %0d exp 3", rcv_q.size());
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rcv_q.size() <= k || rcv_q[k] !== seq[k]) begin
                errors++;
                $display("FAIL b2b_byte%0d got %h exp %h", k, (rcv_q.size() > k) ? rcv_q[k] : 8'hxx, seq[k]);
            end
        end
        r0 = rcv_cnt;
        transmit_i = 1'b1;
        tx_byte_i  = 8'h5A;
        step();
        transmit_i = 1'b0;
        repeat (300) step();
        rst_ni = 1'b0;
        #1;
        checks++;
        if (tx_o !== 1'b1 || is_transmitting_o !== 1'b0 || is_receiving_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got tx=%b txb=%b rxb=%b exp 1 0 0", tx_o, is_transmitting_o, is_receiving_o);
        end
        repeat (5) step();
        rst_ni = 1'b1;
        repeat (800) step();
        checks++;
        if (rcv_cnt !== r0 || err_cnt !== e0 || rx_byte_o !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_after got rcv=%0d err=%0d byte=%h exp 0 0 00", rcv_cnt - r0, err_cnt - e0, rx_byte_o);
        end
        checks++;
        if (both_cnt !== 0 || dbl_cnt !== 0) begin
            errors++;
            $display("FAIL pulse_shape got overlap=%0d repeat=%0d exp 0 0", both_cnt, dbl_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx();
        test_glitch();
        test_framing();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
